// File: rtl/behavior_mmc.sv
// behavior_mmc
//   Computes the GCD and the LCM of two 8-bit unsigned operands. The design
//   uses a multi-cycle datapath:
//     GCD : repeated subtraction until a == b (the GCD is g)
//     DIV : q = X / g by repeated subtraction
//     MUL : LCM = q * Y by 8-step shift-and-add
//   If either operand is zero, the LCM is 0 and the GCD is max(X, Y).
//
// Handshake: start_i is a request. It is accepted only when the FSM is in
//   IDLE and enb_i is high; a request at any other time is dropped. busy_o
//   is high from acceptance until the FSM returns to IDLE. done_o is high
//   for the single enabled cycle spent in DONE, when mmc_o/mdc_o are valid.
//   Those results then hold until the next completion or reset.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (wins over enb_i and start_i)
//   enb_i        clock enable; low freezes every register
//   start_i      compute request
//   dtx_i        operand X
//   dty_i        operand Y
//   busy_o       high in every state except IDLE
//   done_o       high while in DONE (one enabled cycle)
//   mmc_o        LCM(X, Y), 16 bits
//   mdc_o        GCD(X, Y), 8 bits
//   dbg_state_o  current FSM state encoding, for observation
module behavior_mmc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enb_i,
    input  logic        start_i,
    input  logic [7:0]  dtx_i,
    input  logic [7:0]  dty_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] mmc_o,
    output logic [7:0]  mdc_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GCD  = 3'd1,
        S_DIV  = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;

    logic [7:0]  a_q, b_q, xs_q, ys_q;
    logic [7:0]  g_q, rem_q, q_q;
    logic [15:0] acc_q;
    logic [2:0]  bit_q;

    logic        zero_op;
    logic [7:0]  max_op;
    logic [15:0] mul_term;
    logic [15:0] acc_sum;

    // A zero operand skips the arithmetic entirely.
    assign zero_op = (dtx_i == 8'd0) || (dty_i == 8'd0);
    assign max_op  = (dtx_i > dty_i) ? dtx_i : dty_i;

    // The partial product for the current multiplier bit.
    // After step 7, acc_sum is the finished product and is loaded into
    // mmc_o directly.
    assign mul_term = q_q[bit_q] ? ({8'd0, ys_q} << bit_q) : 16'd0;
    assign acc_sum  = acc_q + mul_term;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else if (enb_i) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = zero_op ? S_DONE : S_GCD;
                end
            end
            S_GCD: begin
                if (a_q == b_q) begin
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (rem_q < g_q) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (bit_q == 3'd7) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q   <= 8'd0;
            b_q   <= 8'd0;
            xs_q  <= 8'd0;
            ys_q  <= 8'd0;
            g_q   <= 8'd0;
            rem_q <= 8'd0;
            q_q   <= 8'd0;
            acc_q <= 16'd0;
            bit_q <= 3'd0;
            mmc_o <= 16'd0;
            mdc_o <= 8'd0;
        end else if (enb_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q  <= dtx_i;
                        b_q  <= dty_i;
                        xs_q <= dtx_i;
                        ys_q <= dty_i;
                        if (zero_op) begin
                            mmc_o <= 16'd0;
                            mdc_o <= max_op;
                        end
                    end
                end
                S_GCD: begin
                    if (a_q > b_q) begin
                        a_q <= a_q - b_q;
                    end else if (b_q > a_q) begin
                        b_q <= b_q - a_q;
                    end else begin
                        g_q   <= a_q;
                        rem_q <= xs_q;
                        q_q   <= 8'd0;
                    end
                end
                S_DIV: begin
                    // g >= 1, so q never exceeds xs (<= 255).
                    if (rem_q >= g_q) begin
                        rem_q <= rem_q - g_q;
                        q_q   <= q_q + 8'd1;
                    end else begin
                        acc_q <= 16'd0;
                        bit_q <= 3'd0;
                    end
                end
                S_MUL: begin
                    acc_q <= acc_sum;
                    bit_q <= bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        mmc_o <= acc_sum;
                        mdc_o <= g_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_behavior_mmc.sv
// Directed testbench for behavior_mmc. A cycle is defined by its rising
// edge. Inputs are driven and outputs are sampled 1 ns after that edge.
// Cycle 0 is the cycle in which start_i is presented.
module tb_behavior_mmc;

    logic        clk;
    logic        rst;
    logic        enb;
    logic        start;
    logic [7:0]  dtx;
    logic [7:0]  dty;
    logic        busy_o;
    logic        done_o;
    logic [15:0] mmc_o;
    logic [7:0]  mdc_o;
    logic [2:0]  dbg_state_o;

    int n_checks;
    int n_pass;

    behavior_mmc dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enb_i       (enb),
        .start_i     (start),
        .dtx_i       (dtx),
        .dty_i       (dty),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mmc_o       (mmc_o),
        .mdc_o       (mdc_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Driver: presents one request in cycle 0, then waits for done_o.
    // It returns the cycle in which done_o appears; if done_o never
    // appears within max_cyc cycles, it returns -1. The task finishes in
    // the done cycle.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                         input int max_cyc, output int lat);
        dtx   = x;
        dty   = y;
        start = 1'b1;
        tick;
        start = 1'b0;
        lat   = 1;
        while (!done_o && lat < max_cyc) begin
            tick;
            lat++;
        end
        if (!done_o) lat = -1;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        enb   = 1'b1;
        start = 1'b1;
        dtx   = 8'd3;
        dty   = 8'd4;
        tick;
        tick;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy_o); else n_pass++;
        n_checks++; if (done_o !== 1'b0) $display("FAIL reset_done: got %0b want 0", done_o); else n_pass++;
        n_checks++; if (mmc_o !== 16'd0) $display("FAIL reset_mmc: got %0d want 0", mmc_o); else n_pass++;
        n_checks++; if (mdc_o !== 8'd0) $display("FAIL reset_mdc: got %0d want 0", mdc_o); else n_pass++;
        n_checks++; if (dbg_state_o !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state_o); else n_pass++;
        start = 1'b0;
        rst   = 1'b0;
        tick;
    endtask

    // Case: X=5, Y=5. Expect busy_o in cycles 1-11 and done_o only in cycle 12.
    task automatic test_equal_timing;
        dtx   = 8'd5;
        dty   = 8'd5;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick;
            start = 1'b0;
            n_checks++; if (busy_o !== 1'b1) $display("FAIL eq_busy_c%0d: got %0b want 1", c, busy_o); else n_pass++;
            n_checks++; if (done_o !== (c == 12)) $display("FAIL eq_done_c%0d: got %0b want %0b", c, done_o, (c == 12)); else n_pass++;
        end
        n_checks++; if (mdc_o !== 8'd5) $display("FAIL eq_mdc: got %0d want 5", mdc_o); else n_pass++;
        n_checks++; if (mmc_o !== 16'd5) $display("FAIL eq_mmc: got %0d want 5", mmc_o); else n_pass++;
        tick;
        n_checks++; if (done_o !== 1'b0) $display("FAIL eq_done_pulse: got %0b want 0", done_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL eq_idle_busy: got %0b want 0", busy_o); else n_pass++;
    endtask

    // Additional GCD/LCM pairs. Latency = 1 + GCD steps + (q+1) + 8.
    task automatic test_gcd_lcm;
        int lat;
        // 12,18: GCD steps 3, q=2 -> 1+3+3+8 = 15
        do_op(8'd12, 8'd18, 100, lat);
        n_checks++; if (lat !== 15) $display("FAIL l12_18_lat: got %0d want 15", lat); else n_pass++;
        n_checks++; if (mdc_o !== 8'd6) $display("FAIL l12_18_mdc: got %0d want 6", mdc_o); else n_pass++;
        n_checks++; if (mmc_o !== 16'd36) $display("FAIL l12_18_mmc: got %0d want 36", mmc_o); else n_pass++;
        tick;
        // Results must hold while idle.
        repeat (4) tick;
        n_checks++; if (mmc_o !== 16'd36) $display("FAIL hold_mmc: got %0d want 36", mmc_o); else n_pass++;
        n_checks++; if (done_o !== 1'b0) $display("FAIL hold_done: got %0b want 0", done_o); else n_pass++;
        // 255,254: GCD steps 255, q=255 -> 1+255+256+8 = 520
        do_op(8'd255, 8'd254, 1000, lat);
        n_checks++; if (lat !== 520) $display("FAIL l255_lat: got %0d want 520", lat); else n_pass++;
        n_checks++; if (mdc_o !== 8'd1) $display("FAIL l255_mdc: got %0d want 1", mdc_o); else n_pass++;
        n_checks++; if (mmc_o !== 16'd64770) $display("FAIL l255_mmc: got %0d want 64770", mmc_o); else n_pass++;
        tick;
        // 16,4 -> gcd 4, lcm 16 (back to back with the previous op)
        do_op(8'd16, 8'd4, 200, lat);
        n_checks++; if (mdc_o !== 8'd4) $display("FAIL l16_4_mdc: got %0d want 4", mdc_o); else n_pass++;
        n_checks++; if (mmc_o !== 16'd16) $display("FAIL l16_4_mmc: got %0d want 16", mmc_o); else n_pass++;
        tick;
    endtask

    task automatic test_zero;
        int lat;
        do_op(8'd0, 8'd7, 20, lat);
        n_checks++; if (lat !== 1) $display("FAIL z0_7_lat: got %0d want 1", lat); else n_pass++;
        n_checks++; if (mmc_o !== 16'd0) $display("FAIL z0_7_mmc: got %0d want 0", mmc_o); else n_pass++;
        n_checks++; if (mdc_o !== 8'd7) $display("FAIL z0_7_mdc: got %0d want 7", mdc_o); else n_pass++;
        tick;
        do_op(8'd9, 8'd0, 20, lat);
        n_checks++; if (mdc_o !== 8'd9) $display("FAIL z9_0_mdc: got %0d want 9", mdc_o); else n_pass++;
        tick;
        do_op(8'd0, 8'd0, 20, lat);
        n_checks++; if (lat !== 1) $display("FAIL z0_0_lat: got %0d want 1", lat); else n_pass++;
        n_checks++; if (mmc_o !== 16'd0) $display("FAIL z0_0_mmc: got %0d want 0", mmc_o); else n_pass++;
        n_checks++; if (mdc_o !== 8'd0) $display("FAIL z0_0_mdc: got %0d want 0", mdc_o); else n_pass++;
        tick;
    endtask

    // A second request while busy must be ignored.
    task automatic test_start_while_busy;
        int c;
        bit extra_done;
        dtx   = 8'd12;
        dty   = 8'd18;
        start = 1'b1;
        tick;
        c = 1;
        // Present a different request in cycles 1..4; it should be ignored.
        dtx   = 8'd9;
        dty   = 8'd3;
        while (!done_o && c < 100) begin
            start = (c <= 4);
            tick;
            c++;
        end
        start = 1'b0;
        n_checks++; if (c !== 15) $display("FAIL busy_start_lat: got %0d want 15", c); else n_pass++;
        n_checks++; if (mmc_o !== 16'd36) $display("FAIL busy_start_mmc: got %0d want 36", mmc_o); else n_pass++;
        n_checks++; if (mdc_o !== 8'd6) $display("FAIL busy_start_mdc: got %0d want 6", mdc_o); else n_pass++;
        extra_done = 1'b0;
        repeat (30) begin
            tick;
            if (done_o) extra_done = 1'b1;
        end
        n_checks++; if (extra_done !== 1'b0) $display("FAIL busy_start_extra_done: got %0b want 0", extra_done); else n_pass++;
    endtask

    // Drive enb_i low for 5 cycles during DIV (cycles 4-6 for 12,18).
    // The done_o pulse must shift by 5 cycles (from 15 to 20), and it must
    // hold while enb_i is low in DONE.
    task automatic test_enable;
        int c;
        dtx   = 8'd12;
        dty   = 8'd18;
        start = 1'b1;
        tick;
        start = 1'b0;
        c = 1;
        while (!done_o && c < 100) begin
            enb = !(c >= 5 && c <= 9);
            tick;
            c++;
        end
        enb = 1'b1;
        n_checks++; if (c !== 20) $display("FAIL enb_lat: got %0d want 20", c); else n_pass++;
        n_checks++; if (mmc_o !== 16'd36) $display("FAIL enb_mmc: got %0d want 36", mmc_o); else n_pass++;
        n_checks++; if (mdc_o !== 8'd6) $display("FAIL enb_mdc: got %0d want 6", mdc_o); else n_pass++;
        enb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            n_checks++; if (done_o !== 1'b1) $display("FAIL enb_done_hold_%0d: got %0b want 1", k, done_o); else n_pass++;
        end
        enb = 1'b1;
        tick;
        n_checks++; if (done_o !== 1'b0) $display("FAIL enb_done_release: got %0b want 0", done_o); else n_pass++;
    endtask

    // Reset asserted during MUL (cycle 9 for 12,18) while enb_i is low.
    // The reset must still take effect.
    task automatic test_reset_mid;
        bit seen_done;
        int lat;
        dtx   = 8'd12;
        dty   = 8'd18;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (8) tick;
        n_checks++; if (dbg_state_o !== 3'd3) $display("FAIL rmid_in_mul: got %0d want 3", dbg_state_o); else n_pass++;
        rst = 1'b1;
        enb = 1'b0;
        tick;
        rst = 1'b0;
        enb = 1'b1;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rmid_busy: got %0b want 0", busy_o); else n_pass++;
        n_checks++; if (mmc_o !== 16'd0) $display("FAIL rmid_mmc: got %0d want 0", mmc_o); else n_pass++;
        n_checks++; if (mdc_o !== 8'd0) $display("FAIL rmid_mdc: got %0d want 0", mdc_o); else n_pass++;
        seen_done = done_o;
        repeat (20) begin
            tick;
            if (done_o) seen_done = 1'b1;
        end
        n_checks++; if (seen_done !== 1'b0) $display("FAIL rmid_no_done: got %0b want 0", seen_done); else n_pass++;
        // 7,3: GCD steps 5, q=7 -> 1+5+8+8 = 22
        do_op(8'd7, 8'd3, 100, lat);
        n_checks++; if (lat !== 22) $display("FAIL rmid_new_lat: got %0d want 22", lat); else n_pass++;
        n_checks++; if (mdc_o !== 8'd1) $display("FAIL rmid_new_mdc: got %0d want 1", mdc_o); else n_pass++;
        n_checks++; if (mmc_o !== 16'd21) $display("FAIL rmid_new_mmc: got %0d want 21", mmc_o); else n_pass++;
        tick;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b1;
        enb   = 1'b1;
        start = 1'b0;
        dtx   = 8'd0;
        dty   = 8'd0;
        test_reset;
        test_equal_timing;
        test_gcd_lcm;
        test_zero;
        test_start_while_busy;
        test_enable;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
